swervolf_wb_initiator: RTL

Wishbone classic initiator that drives register accesses on the system-controller bus from a simple valid/ready command port. It is the master end of the 6-bit-address, 32-bit-data Wishbone link that the system controller answers as a responder. Commands are buffered in a small FIFO and issued one at a time. Each access returns read data, or a timeout error, on a valid/ready response port. Intended users are a debug/bring-up path or a hardware sequencer that programs the nmi vector, irq enables, timer and display registers without the core.

---
 rtl/swervolf_wb_pkg.sv | 30 +++
 rtl/wb_cmd_fifo.sv | 57 +++++
 rtl/swervolf_wb_initiator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/swervolf_wb_pkg.sv
// Shared types and register map for the system-controller Wishbone initiator.
package swervolf_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RSP
    } wb_state_t;

    localparam int unsigned CMD_ADR_W = 6;

    typedef struct packed {
        logic                 we;
        logic [CMD_ADR_W-1:0] adr;
        logic [31:0]          dat;
        logic [3:0]           sel;
    } wb_cmd_t;

    // System-controller register byte offsets
    localparam logic [CMD_ADR_W-1:0] REG_VER      = 6'h00;
    localparam logic [CMD_ADR_W-1:0] REG_SWIRQ    = 6'h08;
    localparam logic [CMD_ADR_W-1:0] REG_NMIVEC   = 6'h0C;
    localparam logic [CMD_ADR_W-1:0] REG_IRQEN    = 6'h18;
    localparam logic [CMD_ADR_W-1:0] REG_MTIMECMP = 6'h28;
    localparam logic [CMD_ADR_W-1:0] REG_TCNT     = 6'h30;
    localparam logic [CMD_ADR_W-1:0] REG_TEN      = 6'h34;
    localparam logic [CMD_ADR_W-1:0] REG_SEG_LO   = 6'h38;
    localparam logic [CMD_ADR_W-1:0] REG_SEG_HI   = 6'h3C;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally on o_dat.
module wb_cmd_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (o_count == '0);
    assign do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_push = i_push & (~o_full | do_pop);
    assign o_dat   = mem[rptr];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr    <= '0;
            rptr    <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= i_dat;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + (AW+1)'(1);
                2'b01:   o_count <= o_count - (AW+1)'(1);
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/swervolf_wb_initiator.sv
// Wishbone classic initiator: buffered valid/ready commands become single
// bus accesses, each answered by a data or timeout response.
module swervolf_wb_initiator
    import swervolf_wb_pkg::*;
#(
    parameter int unsigned ADR_W       = 6,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_we,
    input  logic [ADR_W-1:0] i_cmd_adr,
    input  logic [31:0]      i_cmd_dat,
    input  logic [3:0]       i_cmd_sel,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_dat,
    output logic             o_rsp_err,
    output logic             o_busy,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack
);

    localparam int unsigned CMD_W    = $bits(wb_cmd_t);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    wb_state_t                   state;
    wb_cmd_t                     push_cmd;
    wb_cmd_t                     head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [15:0]                 timer;

    assign o_cmd_ready = ~fifo_full;
    assign fifo_push   = i_cmd_valid & o_cmd_ready;
    assign fifo_pop    = (state == IDLE) & ~fifo_empty;
    assign o_busy      = (fifo_count != '0) | (state != IDLE);

    // Pack the command port into a FIFO entry
    always_comb begin
        push_cmd     = '0;
        push_cmd.we  = i_cmd_we;
        push_cmd.adr = CMD_ADR_W'(i_cmd_adr);
        push_cmd.dat = i_cmd_dat;
        push_cmd.sel = i_cmd_sel;
    end

    wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_dat   (push_cmd),
        .i_pop   (fifo_pop),
        .o_dat   (head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Access sequencer: issue head, wait for ack or timeout, hold response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        o_wb_we  <= head.we;
                        o_wb_adr <= ADR_W'(head.adr);
                        o_wb_dat <= head.dat;
                        o_wb_sel <= head.sel;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        timer    <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    timer <= timer + 16'd1;
                    if (i_wb_ack) begin
                        o_rsp_dat   <= o_wb_we ? '0 : i_wb_rdt;
                        o_rsp_err   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        state       <= RSP;
                    end else if (timer == TMO_LAST) begin
                        o_rsp_dat   <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_valid <= 1'b1;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
